load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: MEM_WORDS, 1024, number of 32-bit words in the attached data memory; word addresses >= MEM_WORDS are out of range.
REQ-002 SHALL have clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port: clk  input  1  rising-edge clock.
REQ-004 SHALL have port: reset  input  1  asynchronous active-low reset.
REQ-005 SHALL have port: req  input  1  CPU access request, sampled only when busy=0.
REQ-006 SHALL have port: we  input  1  1=store, 0=load.
REQ-007 SHALL have port: size  input  2  00=byte, 01=half, 10=word; 11 is illegal.
REQ-008 SHALL have port: sext  input  1  loads only: 1=sign-extend, 0=zero-extend.
REQ-009 SHALL have port: addr  input  32  byte address.
REQ-010 SHALL have port: wdata  input  32  store data, right-aligned.
REQ-011 SHALL have port: pc  input  32  PC of the requesting instruction, used for tracing.
REQ-012 SHALL have port: busy  output  1  high from accept until return to IDLE.
REQ-013 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-014 SHALL have port: rdata  output  32  extended load result; valid while done=1.
REQ-015 SHALL have port: err  output  1  one-cycle pulse in place of done on a rejected access.
REQ-016 SHALL have port: mem_a  output  32  word-aligned byte address to the data memory.
REQ-017 SHALL have port: mem_wd  output  32  write data to the data memory.
REQ-018 SHALL have port: mem_we  output  1  memory write strobe, committed at the clk edge.
REQ-019 SHALL have port: mem_rd  input  32  combinational memory read data for mem_a.

Function
REQ-020 SHALL implement FSM states IDLE, ACCESS, WRITE and DONE.
REQ-021 SHALL accept in IDLE when req=1: latch we/size/sext/addr/wdata/pc and go to ACCESS.
REQ-022 SHALL check legality in ACCESS: size=11, half with addr[0]=1, word with addr[1:0]!=0, or addr[31:2]>=MEM_WORDS SHALL pulse err for one cycle with mem_we=0, then go to IDLE.
REQ-023 SHALL drive mem_a={addr[31:2],2'b00} throughout ACCESS and WRITE, and 0 otherwise.
REQ-024 SHALL, for a load in ACCESS, capture the selected byte/half of mem_rd (little-endian lane addr[1:0]) extended per sext, and go to DONE.
REQ-025 SHALL, for a word store in ACCESS, assert mem_we=1 with mem_wd=wdata, and go to DONE.
REQ-026 SHALL, for a byte/half store in ACCESS, capture mem_rd and go to WRITE (read-modify-write).
REQ-027 SHALL, in WRITE, assert mem_we=1 with mem_wd=captured word with the addressed lane(s) replaced by wdata[7:0] or wdata[15:0], and go to DONE.
REQ-028 SHALL, in DONE, hold done=1 for exactly one cycle, hold rdata (0 for stores), and go to IDLE.
REQ-029 SHALL have latency from accept edge to done: load/word store 2 cycles; byte/half store 3 cycles.
REQ-030 SHALL assert mem_we only in the ACCESS and WRITE cases above and never more than once per request.
REQ-031 SHALL ignore req while busy=1; req present in DONE is accepted only after IDLE is re-entered.
REQ-032 SHALL never assert done and err in the same cycle.

Reset
REQ-033 SHALL, on reset=0, immediately force state=IDLE and busy=0, done=0, err=0, mem_we=0, rdata=0, mem_a=0, mem_wd=0.
REQ-034 SHALL, on reset mid-operation, abandon the access with no memory write and no done.

Configuration
REQ-035 SHALL, with LSU_TRACE_EN defined, print "@<pc>: *<mem_a> <= <mem_wd>" (hex, 8 digits) on every clk edge where mem_we=1.
REQ-036 SHALL, without LSU_TRACE_EN, produce no simulation output and leave behaviour otherwise identical.

Verification
REQ-037 SHALL cover: memory word 0x10=0x8899AABB; load byte addr 0x11 sext=1 -> done 2 cycles after accept, rdata=0xFFFFFFAA.
REQ-038 SHALL cover: same word; store half addr 0x12 wdata=0x1234 -> one mem_we at WRITE, word becomes 0x1234AABB, done 3 cycles after accept.
REQ-039 SHALL cover: load word addr 0x06 -> err pulse, no done, mem_we never high.
REQ-040 SHALL cover: addr 0x1000 (word 1024) store -> err, memory unchanged.
REQ-041 SHALL cover: reset low during WRITE of a byte store -> mem_we=0 at once, memory unchanged, busy=0.
REQ-042 SHALL cover: req held high continuously -> back-to-back accepts separated by the DONE->IDLE cycle, with no lost or duplicated access.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word loads and stores to a word-wide data memory,
// byte/half stores by read-modify-write. Define LSU_TRACE_EN to print a line per memory write.
module load_store_unit #(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rd,
  output logic [1:0]  state_o
);

  // Handshake: req is sampled only in IDLE (busy=0); each accepted request ends
  // with exactly one cycle of either done or err, after which busy drops.
  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, DONE} state_e;

  state_e      state_q, state_d;
  logic        we_q, sext_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, pc_q;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] word_q, word_d;
  logic        accept;
  logic        illegal;
  logic [1:0]  lane;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;
  logic [31:0] merged;

  assign lane    = addr_q[1:0];
  assign illegal = (size_q == 2'b11)
                 | ((size_q == 2'b01) & addr_q[0])
                 | ((size_q == 2'b10) & (|addr_q[1:0]))
                 | ({2'b00, addr_q[31:2]} >= 32'(MEM_WORDS));

  assign byte_sel = mem_rd[{lane, 3'b000} +: 8];
  assign half_sel = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];

  always_comb begin
    load_val = mem_rd;
    case (size_q)
      2'b00:   load_val = {{24{sext_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_val = {{16{sext_q & half_sel[15]}}, half_sel};
      default: load_val = mem_rd;
    endcase
  end

  // Lane replacement on the word captured in ACCESS, written back from WRITE.
  always_comb begin
    merged = word_q;
    if (size_q == 2'b00) begin
      merged[{lane, 3'b000} +: 8] = wdata_q[7:0];
    end else if (addr_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0] = wdata_q[15:0];
    end
  end

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    word_d  = word_q;
    accept  = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    mem_a   = 32'h0;
    mem_wd  = 32'h0;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          accept  = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        mem_a = {addr_q[31:2], 2'b00};
        if (illegal) begin
          err     = 1'b1;
          rdata_d = 32'h0;
          state_d = IDLE;
        end else if (!we_q) begin
          rdata_d = load_val;
          state_d = DONE;
        end else if (size_q == 2'b10) begin
          mem_we  = 1'b1;
          mem_wd  = wdata_q;
          rdata_d = 32'h0;
          state_d = DONE;
        end else begin
          word_d  = mem_rd;
          rdata_d = 32'h0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        mem_a   = {addr_q[31:2], 2'b00};
        mem_we  = 1'b1;
        mem_wd  = merged;
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      sext_q  <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      pc_q    <= 32'h0;
      rdata_q <= 32'h0;
      word_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      word_q  <= word_d;
      if (accept) begin
        we_q    <= we;
        sext_q  <= sext;
        size_q  <= size;
        addr_q  <= addr;
        wdata_q <= wdata;
        pc_q    <= pc;
      end
    end
  end

  assign busy    = (state_q != IDLE);
  assign rdata   = rdata_q;
  assign state_o = state_q;

`ifdef LSU_TRACE_EN
  always @(posedge clk) begin
    if (reset && mem_we) $display("@%08h: *%08h <= %08h", pc_q, mem_a, mem_wd);
  end
`else
  logic unused_pc;
  assign unused_pc = ^pc_q;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural 1024-word data memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, we, sext;
  logic [1:0]  size;
  logic [31:0] addr, wdata, pc;
  logic        busy, done, err, mem_we;
  logic [31:0] rdata, mem_a, mem_wd, mem_rd;
  logic [1:0]  state_o;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;

  logic [31:0] mem [0:1023];
  logic        pre_we = 1'b0;
  logic [9:0]  pre_a = '0;
  logic [31:0] pre_d = '0;
  logic [31:0] exp_q [$];

  load_store_unit #(.MEM_WORDS(1024)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata), .pc(pc), .busy(busy), .done(done),
    .rdata(rdata), .err(err), .mem_a(mem_a), .mem_wd(mem_wd),
    .mem_we(mem_we), .mem_rd(mem_rd), .state_o(state_o)
  );

  // clock / memory model
  always #5 clk = ~clk;

  assign mem_rd = (mem_a[31:12] == 20'h0) ? mem[mem_a[11:2]] : 32'h0;

  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_a] <= pre_d;
    end else if (mem_we) begin
      we_cnt++;
      if (mem_a[31:12] == 20'h0) mem[mem_a[11:2]] <= mem_wd;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_a = a; pre_d = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Drives one request; latency counts rising edges from the accept edge up to
  // the edge that samples done/err (observed at the preceding falling edge).
  task automatic run_op(input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic got_done,
                        output logic got_err, output logic [31:0] rd);
    @(negedge clk);
    req = 1'b1; we = w; size = sz; sext = sx; addr = a; wdata = wd; pc = pc + 4;
    @(posedge clk);
    lat = 0; got_done = 1'b0; got_err = 1'b0; rd = 32'h0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req = 1'b0;
      lat++;
      if (done || err) begin
        got_done = done; got_err = err; rd = rdata;
        break;
      end
    end
  endtask

  initial begin
    int          lat, w0, n, last, idx;
    logic        gd, ge;
    logic [31:0] rd, e;
    logic [31:0] a_list [3];

    reset = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; sext = 1'b0;
    addr = 32'h0; wdata = 32'h0; pc = 32'h1000;
    #1;
    check("rst_busy",   {31'h0, busy},   32'h0);
    check("rst_done",   {31'h0, done},   32'h0);
    check("rst_err",    {31'h0, err},    32'h0);
    check("rst_mem_we", {31'h0, mem_we}, 32'h0);
    check("rst_rdata",  rdata,           32'h0);
    check("rst_mem_a",  mem_a,           32'h0);
    check("rst_mem_wd", mem_wd,          32'h0);
    check("rst_state",  {30'h0, state_o}, 32'h0);

    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    preload(10'd4, 32'h8899AABB);
    preload(10'd5, 32'h01020304);
    @(negedge clk);
    reset = 1'b1;

    // load byte 0x11 signed
    run_op(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, lat, gd, ge, rd);
    check("lb11_lat",   lat, 32'd2);
    check("lb11_done",  {31'h0, gd}, 32'h1);
    check("lb11_rdata", rd, 32'hFFFFFFAA);

    run_op(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, lat, gd, ge, rd);
    check("lhu12_rdata", rd, 32'h00008899);
    run_op(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, lat, gd, ge, rd);
    check("lh10_rdata", rd, 32'hFFFFAABB);
    run_op(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, lat, gd, ge, rd);
    check("lb13_rdata", rd, 32'hFFFFFF88);
    run_op(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, lat, gd, ge, rd);
    check("lbu10_rdata", rd, 32'h000000BB);

    // half store by read-modify-write
    w0 = we_cnt;
    run_op(1'b1, 2'b01, 1'b0, 32'h12, 32'hDEAD1234, lat, gd, ge, rd);
    check("sh12_lat",   lat, 32'd3);
    check("sh12_done",  {31'h0, gd}, 32'h1);
    check("sh12_rdata", rd, 32'h0);
    check("sh12_wecnt", we_cnt - w0, 32'd1);
    check("sh12_mem",   mem[4], 32'h1234AABB);

    w0 = we_cnt;
    run_op(1'b1, 2'b00, 1'b0, 32'h10, 32'h00000055, lat, gd, ge, rd);
    check("sb10_lat",   lat, 32'd3);
    check("sb10_wecnt", we_cnt - w0, 32'd1);
    check("sb10_mem",   mem[4], 32'h1234AA55);

    w0 = we_cnt;
    run_op(1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, lat, gd, ge, rd);
    check("sw20_lat",   lat, 32'd2);
    check("sw20_wecnt", we_cnt - w0, 32'd1);
    check("sw20_mem",   mem[8], 32'hCAFEF00D);

    // rejected accesses
    w0 = we_cnt;
    run_op(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, lat, gd, ge, rd);
    check("lw06_err",   {31'h0, ge}, 32'h1);
    check("lw06_done",  {31'h0, gd}, 32'h0);
    check("lw06_lat",   lat, 32'd1);
    check("lw06_wecnt", we_cnt - w0, 32'd0);

    w0 = we_cnt;
    run_op(1'b1, 2'b10, 1'b0, 32'h1000, 32'h5A5A5A5A, lat, gd, ge, rd);
    check("sw1000_err",   {31'h0, ge}, 32'h1);
    check("sw1000_done",  {31'h0, gd}, 32'h0);
    check("sw1000_wecnt", we_cnt - w0, 32'd0);
    check("sw1000_mem0",  mem[0], 32'h0);

    run_op(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, lat, gd, ge, rd);
    check("size11_err", {31'h0, ge}, 32'h1);

    run_op(1'b1, 2'b01, 1'b0, 32'h11, 32'h0, lat, gd, ge, rd);
    check("sh11_err", {31'h0, ge}, 32'h1);

    // reset asserted while a byte store sits in WRITE
    w0 = we_cnt;
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b00; sext = 1'b0; addr = 32'h21; wdata = 32'h77;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    check("rw_access_busy", {31'h0, busy}, 32'h1);
    check("rw_access_we",   {31'h0, mem_we}, 32'h0);
    @(negedge clk);
    check("rw_write_we", {31'h0, mem_we}, 32'h1);
    check("rw_write_a",  mem_a, 32'h20);
    reset = 1'b0;
    #1;
    check("rw_rst_we",   {31'h0, mem_we}, 32'h0);
    check("rw_rst_busy", {31'h0, busy}, 32'h0);
    check("rw_rst_done", {31'h0, done}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("rw_wecnt", we_cnt - w0, 32'd0);
    check("rw_mem",   mem[8], 32'hCAFEF00D);
    reset = 1'b1;

    // req held high: back-to-back word loads
    a_list = '{32'h10, 32'h14, 32'h20};
    exp_q.push_back(32'h1234AA55);
    exp_q.push_back(32'h01020304);
    exp_q.push_back(32'hCAFEF00D);
    w0 = we_cnt;
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = 2'b10; sext = 1'b0; addr = a_list[0];
    idx = 0; n = 0; last = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n++;
      if (done) begin
        e = exp_q.pop_front();
        check("b2b_rdata", rdata, e);
        if (idx > 0) check("b2b_gap", n - last, 32'd3);
        last = n;
        idx++;
        if (idx < 3) addr = a_list[idx];
        else req = 1'b0;
      end
      if (idx == 3) break;
    end
    check("b2b_count", idx, 32'd3);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) n++;
    end
    check("b2b_no_extra", n, 32'd0);
    check("b2b_wecnt", we_cnt - w0, 32'd0);
    check("b2b_idle", {31'h0, busy}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
